hit_transition_detector: RTL

Parametrised successor to the fixed 256-strip 0→1 detector in the R3/DCL readout path. Captures a previous-BC strip word and a current-BC strip+header word over a configurable number of buffer-write slots, then evaluates a selectable hit condition. On a hit, or when filtering is disabled, it pulses START to launch readout of the captured word; otherwise it pulses NO_HIT. It sits between the pipeline-memory readback and the cluster finder / readout sequencer.

---
 rtl/htd_pkg.sv | 23 ++
 rtl/hit_reduce.sv | 50 +++++
 rtl/hit_transition_detector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/htd_pkg.sv
// Shared definitions for hit_transition_detector and hit_reduce.
//   - MODE encodings selecting the strip qualification expression
//   - Event FSM state enum
//   - slot_w(): width of the buffer-write slot counter for a given BC
package htd_pkg;

    localparam logic [1:0] HTD_MODE_01  = 2'b00;  // cur & ~prev
    localparam logic [1:0] HTD_MODE_X1  = 2'b01;  // cur
    localparam logic [1:0] HTD_MODE_11  = 2'b10;  // cur & prev
    localparam logic [1:0] HTD_MODE_CHG = 2'b11;  // cur ^ prev

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } htd_state_e;

    // Slot counter must hold the value BC itself
    function automatic int unsigned slot_w(input int unsigned bc);
        return $clog2(bc + 1);
    endfunction

endpackage

// File: rtl/hit_reduce.sv
// Combinational hit qualification over the strip bits.
// Optional popcount of the qualified mask: define HTD_HITCNT_EN.
// Ports:
//   prev       strip word of BC-1
//   cur        strip word of BC (header bits excluded by the caller)
//   mode       qualification select (htd_pkg HTD_MODE_*)
//   any_hit_c  at least one qualifying strip
//   hit_cnt_c  number of qualifying strips (0 when HTD_HITCNT_EN undefined)
module hit_reduce
    import htd_pkg::*;
#(
    parameter  int unsigned NCH = 256,
    localparam int unsigned CW  = $clog2(NCH + 1)
) (
    input  logic [NCH-1:0] prev,
    input  logic [NCH-1:0] cur,
    input  logic [1:0]     mode,
    output logic           any_hit_c,
    output logic [CW-1:0]  hit_cnt_c
);

    logic [NCH-1:0] qual;

    // Per-strip qualification mask
    always_comb begin
        qual = '0;
        case (mode)
            HTD_MODE_01:  qual = cur & ~prev;
            HTD_MODE_X1:  qual = cur;
            HTD_MODE_11:  qual = cur & prev;
            HTD_MODE_CHG: qual = cur ^ prev;
            default:      qual = '0;
        endcase
    end

    assign any_hit_c = |qual;

`ifdef HTD_HITCNT_EN
    // Popcount of the qualified mask
    always_comb begin
        hit_cnt_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            hit_cnt_c = hit_cnt_c + CW'(qual[i]);
        end
    end
`else
    assign hit_cnt_c = '0;
`endif

endmodule

// File: rtl/hit_transition_detector.sv
// Captures a BC-1 strip word and a BC strip+header word over BC accepted
// buffer-write cycles, evaluates the selected hit condition and pulses
// START (readout launch) or NO_HIT. Optional macro: HTD_HITCNT_EN enables
// the qualifying-strip popcount on HIT_CNT (tied to 0 otherwise).
// Ports:
//   CLK, RST     clock (rising edge), synchronous active-low reset
//   MEM_PREV     strip word of BC-1
//   MEM_CUR      strip+header word of BC, strips in [NCH-1:0]
//   WR_PREV/CUR  buffer-write strobes that load the word registers
//   WR_NEXT      buffer-write strobe for BC+1, advances the slot only
//   BUSY         downstream busy, stalls (drops) the write this cycle
//   EN, MODE     filter enable and qualification select, sampled in EVAL
//   DATA_OUT     captured current word
//   START        one-cycle readout-launch pulse
//   NO_HIT       one-cycle pulse for a filtered event without hits
//   HIT_CNT      qualifying-strip count, updated in EVAL
module hit_transition_detector
    import htd_pkg::*;
#(
    parameter  int unsigned NCH = 256,
    parameter  int unsigned HDR = 16,
    parameter  int unsigned BC  = 3,
    localparam int unsigned DW  = NCH + HDR,
    localparam int unsigned SW  = slot_w(BC),
    localparam int unsigned CW  = $clog2(NCH + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] MEM_PREV,
    input  logic [DW-1:0]  MEM_CUR,
    input  logic           WR_PREV,
    input  logic           WR_CUR,
    input  logic           WR_NEXT,
    input  logic           BUSY,
    input  logic           EN,
    input  logic [1:0]     MODE,
    output logic [DW-1:0]  DATA_OUT,
    output logic           START,
    output logic           NO_HIT,
    output logic [CW-1:0]  HIT_CNT
);

    htd_state_e     state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [NCH-1:0] prev_q, prev_d;
    logic [DW-1:0]  cur_q, cur_d;
    logic           start_q, start_d;
    logic           no_hit_q, no_hit_d;
    logic [CW-1:0]  hit_cnt_q, hit_cnt_d;
    logic           any_hit_c;
    logic [CW-1:0]  hit_cnt_c;

    // Qualification uses strip bits only; the header never qualifies
    hit_reduce #(
        .NCH (NCH)
    ) u_hit_reduce (
        .prev      (prev_q),
        .cur       (cur_q[NCH-1:0]),
        .mode      (MODE),
        .any_hit_c (any_hit_c),
        .hit_cnt_c (hit_cnt_c)
    );

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            prev_q    <= '0;
            cur_q     <= '0;
            start_q   <= 1'b0;
            no_hit_q  <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            start_q   <= start_d;
            no_hit_q  <= no_hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        prev_d    = prev_q;
        cur_d     = cur_q;
        start_d   = 1'b0;
        no_hit_d  = 1'b0;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            IDLE: begin
                // One slot per accepted cycle, however many strobes are high
                if ((WR_PREV || WR_CUR || WR_NEXT) && !BUSY && (slot_q < SW'(BC))) begin
                    slot_d = slot_q + SW'(1);
                    if (WR_PREV) prev_d = MEM_PREV;
                    if (WR_CUR)  cur_d  = MEM_CUR;
                    if (slot_d == SW'(BC)) state_d = EVAL;
                end
            end
            EVAL: begin
                state_d   = DONE;
                hit_cnt_d = hit_cnt_c;
                if (!EN || any_hit_c) start_d  = 1'b1;
                else                  no_hit_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                slot_d  = '0;
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase
    end

    assign DATA_OUT = cur_q;
    assign START    = start_q;
    assign NO_HIT   = no_hit_q;
    assign HIT_CNT  = hit_cnt_q;

endmodule
